// File: rtl/sm_noc_pkg.sv
// Shared flit layout and helpers for the mesh network interface.
package sm_noc_pkg;

  localparam int FLIT_W   = 37;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int END_BIT  = 4;
  localparam int DATA_MSB = 36;
  localparam int DATA_LSB = 5;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } txState_e;

  function automatic logic [FLIT_W-1:0] packFlit(
    input logic [DATA_W-1:0] data,
    input logic [ADDR_W-1:0] dest
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[DATA_MSB:DATA_LSB] = data;
    f[END_BIT] = 1'b1;
    f[ADDR_W-1:0] = dest;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] flitData(
    input logic [FLIT_W-1:0] f
  );
    return f[DATA_MSB:DATA_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] flitDest(
    input logic [FLIT_W-1:0] f
  );
    return f[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sm_noc_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head shown combinationally.
module sm_noc_fifo #(
  parameter int WIDTH      = 37,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  input  logic                  pop,
  output logic [WIDTH-1:0]      popData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wrPtr;
  logic [DEPTH_LOG2:0] rdPtr;
  logic                doPush;
  logic                doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]) &&
                 (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]);
  assign count = wrPtr - rdPtr;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Empty head reads as zero so consumers never see stale storage.
  assign popData = empty ? '0 : mem[rdPtr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[DEPTH_LOG2-1:0]] <= pushData;
  end

endmodule

// File: rtl/sm_noc_ni.sv
// CPU <-> router local-port network interface (TX packer, RX filter).
// Optional SM_NI_LOOPBACK_EN: local-dest words bypass the router.
module sm_noc_ni
  import sm_noc_pkg::*;
#(
  parameter logic [3:0] POSITION      = 4'b0000,
  parameter int         TX_DEPTH_LOG2 = 2,
  parameter int         RX_DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_tx_data,
  input  logic [3:0]        cpu_tx_dest,
  input  logic              cpu_tx_valid,
  output logic              cpu_tx_ready,
  output logic [31:0]       cpu_rx_data,
  output logic              cpu_rx_valid,
  input  logic              cpu_rx_pop,
  output logic [36:0]       flit_out,
  output logic              flit_out_req,
  input  logic              router_rdy,
  input  logic [36:0]       flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ack,
  output logic [7:0]        misroute_cnt
);

  localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT =
    (TX_DEPTH_LOG2+1)'(1 << TX_DEPTH_LOG2);

  txState_e state, stateNext;

  logic [FLIT_W-1:0]      txHead;
  logic                   txEmpty;
  logic                   txFull;
  logic [TX_DEPTH_LOG2:0] txCount;
  logic                   txPush;
  logic                   txPop;
  logic                   loadFlit;

  logic                   rxFull;
  logic                   rxEmpty;
  logic [RX_DEPTH_LOG2:0] rxCount;
  logic                   rxPush;
  logic [DATA_W-1:0]      rxPushData;
  logic                   rxMatch;
  logic                   routerPush;
  logic                   loopPush;
  logic                   headLocal;
  logic                   loopOk;
  logic                   unusedFifo;

  assign cpu_tx_ready = (txCount != TX_FULL_CNT);
  assign txPush       = cpu_tx_valid && cpu_tx_ready;
  assign unusedFifo   = ^{txFull, rxCount};

  sm_noc_fifo #(
    .WIDTH      (FLIT_W),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) txFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (txPush),
    .pushData (packFlit(cpu_tx_data, cpu_tx_dest)),
    .pop      (txPop),
    .popData  (txHead),
    .full     (txFull),
    .empty    (txEmpty),
    .count    (txCount)
  );

  assign rxMatch     = (flitDest(flit_in) == POSITION);
  assign flit_in_ack = flit_in_valid && (!rxFull || !rxMatch);
  assign routerPush  = flit_in_ack && rxMatch;

`ifdef SM_NI_LOOPBACK_EN
  assign headLocal = !txEmpty && (flitDest(txHead) == POSITION);
`else
  assign headLocal = 1'b0;
`endif

  // Router deliveries take the RX write port first; loopback retries.
  assign loopOk = headLocal && !rxFull && !routerPush;

  assign rxPush     = routerPush || loopPush;
  assign rxPushData = routerPush ? flitData(flit_in) : flitData(txHead);

  sm_noc_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) rxFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rxPush),
    .pushData (rxPushData),
    .pop      (cpu_rx_pop),
    .popData  (cpu_rx_data),
    .full     (rxFull),
    .empty    (rxEmpty),
    .count    (rxCount)
  );

  assign cpu_rx_valid = !rxEmpty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TX_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      TX_IDLE: if (!txEmpty && !headLocal) stateNext = TX_SEND;
      TX_SEND: if (router_rdy && txEmpty)  stateNext = TX_IDLE;
      default: stateNext = TX_IDLE;
    endcase
  end

  always_comb begin
    txPop        = 1'b0;
    loadFlit     = 1'b0;
    loopPush     = 1'b0;
    flit_out_req = (state == TX_SEND);
    unique case (state)
      TX_IDLE: begin
        if (headLocal) begin
          loopPush = loopOk;
          txPop    = loopOk;
        end else if (!txEmpty) begin
          txPop    = 1'b1;
          loadFlit = 1'b1;
        end
      end
      TX_SEND: begin
        if (router_rdy && !txEmpty) begin
          txPop    = 1'b1;
          loadFlit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         flit_out <= '0;
    else if (loadFlit) flit_out <= txHead;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_cnt <= '0;
    end else if (flit_in_ack && !rxMatch && misroute_cnt != 8'hFF) begin
      misroute_cnt <= misroute_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sm_noc_ni.sv
// Scoreboard bench for sm_noc_ni at POSITION=3 (honours SM_NI_LOOPBACK_EN).
module tb_sm_noc_ni;

  localparam logic [3:0] POS = 4'h3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_tx_data = '0;
  logic [3:0]  cpu_tx_dest = '0;
  logic        cpu_tx_valid = 1'b0;
  logic        cpu_tx_ready;
  logic [31:0] cpu_rx_data;
  logic        cpu_rx_valid;
  logic        cpu_rx_pop = 1'b0;
  logic [36:0] flit_out;
  logic        flit_out_req;
  logic        router_rdy = 1'b0;
  logic [36:0] flit_in = '0;
  logic        flit_in_valid = 1'b0;
  logic        flit_in_ack;
  logic [7:0]  misroute_cnt;

  sm_noc_ni #(
    .POSITION      (POS),
    .TX_DEPTH_LOG2 (2),
    .RX_DEPTH_LOG2 (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_tx_data   (cpu_tx_data),
    .cpu_tx_dest   (cpu_tx_dest),
    .cpu_tx_valid  (cpu_tx_valid),
    .cpu_tx_ready  (cpu_tx_ready),
    .cpu_rx_data   (cpu_rx_data),
    .cpu_rx_valid  (cpu_rx_valid),
    .cpu_rx_pop    (cpu_rx_pop),
    .flit_out      (flit_out),
    .flit_out_req  (flit_out_req),
    .router_rdy    (router_rdy),
    .flit_in       (flit_in),
    .flit_in_valid (flit_in_valid),
    .flit_in_ack   (flit_in_ack),
    .misroute_cnt  (misroute_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int misModel = 0;
  bit lbMode = 1'b0;
  logic [36:0] txExp[$];
  logic [31:0] rxExp[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [36:0] mkFlit(input logic [31:0] d,
                                         input logic [3:0] a);
    return {d, 1'b1, a};
  endfunction

  // Monitor: compares at the falling edge what the next rising edge commits.
  always @(negedge clk) begin
    logic expAck;
    if (!reset) begin
      if (flit_out_req && router_rdy) begin
        if (txExp.size() == 0) begin
          checks++;
          $display("FAIL tx_extra: got flit %0h expected none", flit_out);
        end else begin
          check("tx_flit", {27'd0, flit_out}, {27'd0, txExp.pop_front()});
        end
      end
      expAck = flit_in_valid && (rxExp.size() < 4 || flit_in[3:0] != POS);
      check("rx_ack", {63'd0, flit_in_ack}, {63'd0, expAck});
      check("misroute", {56'd0, misroute_cnt}, 64'(misModel));
      if (!lbMode) begin
        check("rx_valid", {63'd0, cpu_rx_valid}, {63'd0, rxExp.size() != 0});
        if (cpu_rx_pop && cpu_rx_valid && rxExp.size() != 0)
          check("rx_data", {32'd0, cpu_rx_data}, {32'd0, rxExp.pop_front()});
        if (flit_in_valid && flit_in_ack) begin
          if (flit_in[3:0] == POS) rxExp.push_back(flit_in[36:5]);
          else if (misModel < 255) misModel++;
        end
      end
    end
  end

  task automatic doReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    txExp.delete();
    rxExp.delete();
    misModel = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic txWord(input logic [31:0] d, input logic [3:0] a);
    int waited = 0;
    cpu_tx_data  = d;
    cpu_tx_dest  = a;
    cpu_tx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cpu_tx_ready) begin
        txExp.push_back(mkFlit(d, a));
        break;
      end
      if (++waited > 300) begin
        checks++;
        $display("FAIL tx_timeout: got ready=0 expected ready within 300");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cpu_tx_valid = 1'b0;
  endtask

  task automatic rxFlit(input logic [31:0] d, input logic [3:0] a);
    int waited = 0;
    flit_in       = mkFlit(d, a);
    flit_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (flit_in_ack) break;
      if (++waited > 300) begin
        checks++;
        $display("FAIL rx_timeout: got ack=0 expected ack within 300");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    flit_in_valid = 1'b0;
  endtask

  task automatic noReqFor(input int n, input string name);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (flit_out_req) seen = 1'b1;
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  logic [3:0] rdest;
  bit         txDone;
  bit         rxDone;
  int         reqCnt;
  int         reqIdx;

  initial begin
    // Reset values while reset is held
    #3;
    check("rst_req", {63'd0, flit_out_req}, 64'd0);
    check("rst_flit", {27'd0, flit_out}, 64'd0);
    check("rst_ack", {63'd0, flit_in_ack}, 64'd0);
    check("rst_rxv", {63'd0, cpu_rx_valid}, 64'd0);
    check("rst_rxd", {32'd0, cpu_rx_data}, 64'd0);
    check("rst_mis", {56'd0, misroute_cnt}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {63'd0, cpu_tx_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Latency and reset in the middle of SEND
    txWord(32'hCAFE0001, 4'h5);
    @(negedge clk);
    check("lat_n", {63'd0, flit_out_req}, 64'd0);
    @(negedge clk);
    check("lat_n1", {63'd0, flit_out_req}, 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    txExp.delete();
    #1;
    check("async_req", {63'd0, flit_out_req}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_req", {63'd0, flit_out_req}, 64'd0);
    check("mid_ready", {63'd0, cpu_tx_ready}, 64'd1);
    check("mid_rxv", {63'd0, cpu_rx_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Single flit with router ready: one-cycle request
    router_rdy = 1'b1;
    txWord(32'hDEADBEEF, 4'h5);
    reqCnt = 0;
    reqIdx = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (flit_out_req) begin
        reqCnt++;
        reqIdx = i;
        check("beef_flit", {27'd0, flit_out}, {27'd0, 37'h1BD5B7DDF5});
      end
    end
    check("beef_cnt", 64'(reqCnt), 64'd1);
    check("beef_idx", 64'(reqIdx), 64'd1);
    @(posedge clk);
    #1;

    // Five words into a stalled router, then a consecutive burst
    router_rdy = 1'b0;
    for (int i = 0; i < 5; i++) txWord(32'h1000 + 32'(i), 4'(i + 8));
    @(negedge clk);
    check("fill_ready", {63'd0, cpu_tx_ready}, 64'd0);
    cpu_tx_data  = 32'hBAD;
    cpu_tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_hold", {63'd0, cpu_tx_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    cpu_tx_valid = 1'b0;
    router_rdy   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("burst_req", {63'd0, flit_out_req}, 64'd1);
    end
    @(negedge clk);
    check("burst_end", {63'd0, flit_out_req}, 64'd0);
    check("burst_q", 64'(txExp.size()), 64'd0);
    @(posedge clk);
    #1;
    router_rdy = 1'b0;

    // RX backpressure with the CPU not popping
    for (int i = 0; i < 4; i++) rxFlit(32'hA000 + 32'(i), POS);
    flit_in       = mkFlit(32'hA004, POS);
    flit_in_valid = 1'b1;
    @(negedge clk);
    check("bp_ack0", {63'd0, flit_in_ack}, 64'd0);
    @(negedge clk);
    check("bp_ack1", {63'd0, flit_in_ack}, 64'd0);
    @(posedge clk);
    #1;
    cpu_rx_pop = 1'b1;
    @(posedge clk);
    #1;
    cpu_rx_pop = 1'b0;
    @(negedge clk);
    check("bp_release", {63'd0, flit_in_ack}, 64'd1);
    @(posedge clk);
    #1;
    flit_in_valid = 1'b0;
    cpu_rx_pop    = 1'b1;
    for (int i = 0; i < 20 && rxExp.size() != 0; i++) @(posedge clk);
    #1;
    cpu_rx_pop = 1'b0;
    check("bp_drain", 64'(rxExp.size()), 64'd0);

    // Misrouted flits and saturation
    rxFlit(32'h99, 4'h9);
    @(negedge clk);
    check("mis_one", {56'd0, misroute_cnt}, 64'd1);
    @(posedge clk);
    #1;
    flit_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      flit_in = mkFlit($urandom, 4'h9);
      @(posedge clk);
      #1;
    end
    flit_in_valid = 1'b0;
    @(negedge clk);
    check("mis_sat", {56'd0, misroute_cnt}, 64'd255);
    check("mis_norx", {63'd0, cpu_rx_valid}, 64'd0);

    // Randomized concurrent traffic
    doReset();
    txDone = 1'b0;
    rxDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          rdest = 4'($urandom_range(0, 15));
`ifdef SM_NI_LOOPBACK_EN
          if (rdest == POS) rdest = 4'hC;
`endif
          txWord($urandom, rdest);
        end
        txDone = 1'b1;
      end
      begin
        for (int i = 0; i < 150; i++) begin
          rdest = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : POS;
          rxFlit($urandom, rdest);
        end
        rxDone = 1'b1;
      end
      begin
        while (!(txDone && rxDone)) begin
          @(posedge clk);
          #1;
          router_rdy = 1'($urandom_range(0, 1));
          cpu_rx_pop = 1'($urandom_range(0, 1));
        end
      end
    join
    router_rdy = 1'b1;
    cpu_rx_pop = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (txExp.size() == 0 && rxExp.size() == 0 && !flit_out_req) break;
      @(posedge clk);
    end
    #1;
    cpu_rx_pop = 1'b0;
    router_rdy = 1'b0;
    check("rand_txq", 64'(txExp.size()), 64'd0);
    check("rand_rxq", 64'(rxExp.size()), 64'd0);

`ifdef SM_NI_LOOPBACK_EN
    // Loopback alone, then racing a router delivery
    doReset();
    lbMode = 1'b1;
    txWord(32'h12345678, POS);
    txExp.delete();
    noReqFor(4, "lb_noreq");
    check("lb_valid", {63'd0, cpu_rx_valid}, 64'd1);
    check("lb_data", {32'd0, cpu_rx_data}, 64'h12345678);
    @(posedge clk);
    #1;
    cpu_rx_pop = 1'b1;
    @(posedge clk);
    #1;
    cpu_rx_pop = 1'b0;
    @(negedge clk);
    check("lb_empty", {63'd0, cpu_rx_valid}, 64'd0);
    @(posedge clk);
    #1;
    txWord(32'hAAAA0001, POS);
    txExp.delete();
    flit_in       = mkFlit(32'hBBBB0002, POS);
    flit_in_valid = 1'b1;
    @(posedge clk);
    #1;
    flit_in_valid = 1'b0;
    noReqFor(4, "lb2_noreq");
    check("lb2_first", {32'd0, cpu_rx_data}, 64'hBBBB0002);
    @(posedge clk);
    #1;
    cpu_rx_pop = 1'b1;
    @(posedge clk);
    #1;
    cpu_rx_pop = 1'b0;
    @(negedge clk);
    check("lb2_second", {32'd0, cpu_rx_data}, 64'hAAAA0001);
    check("lb2_valid", {63'd0, cpu_rx_valid}, 64'd1);
    lbMode = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
